// File: rtl/onchip_memory_dp_pkg.sv
// Shared types and elaboration helpers for the dual-port on-chip RAM.
// state | meaning:  CLEAR | zero sweep through port A, both ports stalled;  RUN | normal access
package onchip_mem_pkg;

    typedef enum logic {CLEAR, RUN} state_t;

    function automatic int rd_latency(int out_reg);
        return (out_reg != 0) ? 2 : 1;
    endfunction

    function automatic bit params_ok(int data_w, int addr_w, int depth);
        return (data_w % 8 == 0) && (depth > 0) && (depth <= (1 << addr_w));
    endfunction

endpackage

// File: rtl/onchip_memory_dp_if.sv
// Avalon-MM slave port bundle for one side of the dual-port RAM.
interface onchip_memory_dp_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 10
) ();
    logic [ADDR_W-1:0]   address;
    logic                chipselect;
    logic                read;
    logic                write;
    logic [DATA_W/8-1:0] byteenable;
    logic [DATA_W-1:0]   writedata;
    logic [DATA_W-1:0]   readdata;
    logic                readdatavalid;
    logic                waitrequest;

    modport master (
        output address, chipselect, read, write, byteenable, writedata,
        input  readdata, readdatavalid, waitrequest
    );

    modport slave (
        input  address, chipselect, read, write, byteenable, writedata,
        output readdata, readdatavalid, waitrequest
    );
endinterface

// File: rtl/onchip_memory_dp_ram_dp_core.sv
// True dual-port byte-enabled RAM, read-first on both ports, common enable.
module ram_dp_core #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 10,
    parameter int DEPTH  = 1024
) (
    input  logic                clk,
    input  logic                en,
    input  logic                a_we,
    input  logic [ADDR_W-1:0]   a_addr,
    input  logic [DATA_W/8-1:0] a_be,
    input  logic [DATA_W-1:0]   a_wdata,
    output logic [DATA_W-1:0]   a_q,
    input  logic                b_we,
    input  logic [ADDR_W-1:0]   b_addr,
    input  logic [DATA_W/8-1:0] b_be,
    input  logic [DATA_W-1:0]   b_wdata,
    output logic [DATA_W-1:0]   b_q
);
    logic [DATA_W-1:0] mem [DEPTH];

    // Port A lanes are assigned last so they win a same-address collision.
    always_ff @(posedge clk) begin
        if (en) begin
            for (int i = 0; i < DATA_W/8; i++) begin
                if (b_we && b_be[i]) mem[b_addr][8*i +: 8] <= b_wdata[8*i +: 8];
                if (a_we && a_be[i]) mem[a_addr][8*i +: 8] <= a_wdata[8*i +: 8];
            end
            a_q <= mem[a_addr];
            b_q <= mem[b_addr];
        end
    end
endmodule

// File: rtl/onchip_memory_dp.sv
// Dual-port Avalon-MM on-chip RAM with optional output register and clear-on-reset sweep.
// state | meaning:  CLEAR | sweep zeroes one word per enabled cycle;  RUN | commands accepted
module onchip_memory_dp
    import onchip_mem_pkg::*;
#(
    parameter int DATA_W         = 32,
    parameter int ADDR_W         = 10,
    parameter int DEPTH          = 1024,
    parameter int OUT_REG        = 0,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic reset_req,
    input  logic clken,
    onchip_memory_dp_if.slave a,
    onchip_memory_dp_if.slave b
);
    localparam int                BE_W      = DATA_W / 8;
    localparam int                RD_LAT    = rd_latency(OUT_REG);
    localparam logic [ADDR_W:0]   DEPTH_L   = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    if (!params_ok(DATA_W, ADDR_W, DEPTH)) begin : g_bad_params
        $error("onchip_memory_dp: DATA_W must be a multiple of 8 and DEPTH <= 2**ADDR_W");
    end

    state_t            state;
    logic [ADDR_W-1:0] clr_addr;
    logic              en, run, stall;

    assign en    = clken & ~reset_req;
    assign run   = (state == RUN);
    assign stall = ~run | ~en;

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= (CLEAR_ON_RESET != 0) ? CLEAR : RUN;
            clr_addr <= '0;
        end else if (en && state == CLEAR) begin
            if (clr_addr == LAST_ADDR) begin
                state    <= RUN;
                clr_addr <= '0;
            end else begin
                clr_addr <= clr_addr + ADDR_W'(1);
            end
        end
    end

    logic              sel    [2];
    logic              rd_req [2];
    logic              wr_req [2];
    logic [ADDR_W-1:0] addr   [2];
    logic              hit    [2];
    logic              wr     [2];
    logic              rvalid [2];
    logic [DATA_W-1:0] rdata  [2];
    logic [DATA_W-1:0] core_q [2];

    assign sel[0]    = a.chipselect;
    assign sel[1]    = b.chipselect;
    assign rd_req[0] = a.read;
    assign rd_req[1] = b.read;
    assign wr_req[0] = a.write;
    assign wr_req[1] = b.write;
    assign addr[0]   = a.address;
    assign addr[1]   = b.address;

    assign a.waitrequest   = stall;
    assign b.waitrequest   = stall;
    assign a.readdatavalid = rvalid[0];
    assign b.readdatavalid = rvalid[1];
    assign a.readdata      = rdata[0];
    assign b.readdata      = rdata[1];

    for (genvar p = 0; p < 2; p++) begin : g_port
        logic              acc, rd_acc, v1, r1, last_v, beat;
        logic [DATA_W-1:0] d1, last_d, hold;

        assign acc    = sel[p] & (rd_req[p] | wr_req[p]) & ~stall;
        assign hit[p] = ({1'b0, addr[p]} < DEPTH_L);
        assign wr[p]  = acc & wr_req[p];
        assign rd_acc = acc & rd_req[p] & ~wr_req[p];
        assign d1     = r1 ? core_q[p] : '0;

        always_ff @(posedge clk) begin
            if (reset) begin
                v1 <= 1'b0;
                r1 <= 1'b0;
            end else if (en) begin
                v1 <= rd_acc;
                r1 <= hit[p];
            end
        end

        if (RD_LAT == 2) begin : g_oreg
            logic              v2;
            logic [DATA_W-1:0] d2;
            always_ff @(posedge clk) begin
                if (reset) begin
                    v2 <= 1'b0;
                    d2 <= '0;
                end else if (en) begin
                    v2 <= v1;
                    d2 <= d1;
                end
            end
            assign last_v = v2;
            assign last_d = d2;
        end else begin : g_noreg
            assign last_v = v1;
            assign last_d = d1;
        end

        // A pending beat waits out stalls and is shown once, on the first enabled cycle.
        assign beat = last_v & en;

        always_ff @(posedge clk) begin
            if (reset)     hold <= '0;
            else if (beat) hold <= last_d;
        end

        assign rvalid[p] = beat;
        assign rdata[p]  = beat ? last_d : hold;
    end

    ram_dp_core #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_core (
        .clk     (clk),
        .en      (en),
        .a_we    (run ? (wr[0] & hit[0]) : 1'b1),
        .a_addr  (run ? a.address : clr_addr),
        .a_be    (run ? a.byteenable : {BE_W{1'b1}}),
        .a_wdata (run ? a.writedata : '0),
        .a_q     (core_q[0]),
        .b_we    (wr[1] & hit[1]),
        .b_addr  (b.address),
        .b_be    (b.byteenable),
        .b_wdata (b.writedata),
        .b_q     (core_q[1])
    );
endmodule

// File: tb/tb_onchip_memory_dp.sv
// Two instances share one stimulus: DEPTH=16/OUT_REG=0 and DEPTH=10/OUT_REG=1,
// both checked against a word-array reference model with per-port beat queues.
module tb_onchip_memory_dp;
    localparam int DW = 32;
    localparam int AW = 4;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic reset_req = 1'b0;
    logic clken = 1'b1;

    logic          s_cs [2], s_rd [2], s_wr [2];
    logic [AW-1:0] s_addr [2];
    logic [3:0]    s_be [2];
    logic [DW-1:0] s_wd [2];

    logic          o_wait [4], o_valid [4];
    logic [DW-1:0] o_data [4];

    always #5 clk = ~clk;

    onchip_memory_dp_if #(.DATA_W(DW), .ADDR_W(AW)) ifc [4] ();

    for (genvar i = 0; i < 4; i++) begin : g_if
        assign ifc[i].chipselect = s_cs[i%2];
        assign ifc[i].read       = s_rd[i%2];
        assign ifc[i].write      = s_wr[i%2];
        assign ifc[i].address    = s_addr[i%2];
        assign ifc[i].byteenable = s_be[i%2];
        assign ifc[i].writedata  = s_wd[i%2];
        assign o_wait[i]         = ifc[i].waitrequest;
        assign o_valid[i]        = ifc[i].readdatavalid;
        assign o_data[i]         = ifc[i].readdata;
    end

    onchip_memory_dp #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(16), .OUT_REG(0), .CLEAR_ON_RESET(1)) u_dut0 (
        .clk(clk), .reset(reset), .reset_req(reset_req), .clken(clken), .a(ifc[0]), .b(ifc[1]));

    onchip_memory_dp #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(10), .OUT_REG(1), .CLEAR_ON_RESET(1)) u_dut1 (
        .clk(clk), .reset(reset), .reset_req(reset_req), .clken(clken), .a(ifc[2]), .b(ifc[3]));

    function automatic int dep_of(int d);
        return (d == 0) ? 16 : 10;
    endfunction

    function automatic int lat_of(int d);
        return (d == 0) ? 1 : 2;
    endfunction

    typedef struct {
        logic [DW-1:0] data;
        int            due;
    } exp_t;

    exp_t          q [4][$];
    logic [DW-1:0] mem [2][16];
    logic [DW-1:0] last_exp [4];
    int            clr_left [2];
    int            ecnt = 0;
    bit            init = 1'b0;
    int            n_chk = 0;
    int            n_err = 0;

    task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: commands are resolved at the accepting edge (reads see old data,
    // then B writes, then A writes so A wins overlapping lanes).
    always @(posedge clk) begin
        logic          en_m;
        logic [DW-1:0] rv;
        en_m = clken & ~reset_req;
        if (reset) begin
            init = 1'b1;
            for (int d = 0; d < 2; d++) begin
                clr_left[d] = dep_of(d);
                for (int w = 0; w < 16; w++) mem[d][w] = '0;
            end
            for (int k = 0; k < 4; k++) begin
                q[k].delete();
                last_exp[k] = '0;
            end
        end else if (en_m) begin
            ecnt++;
            for (int d = 0; d < 2; d++) begin
                if (clr_left[d] > 0) begin
                    clr_left[d]--;
                end else begin
                    for (int p = 0; p < 2; p++) begin
                        if (s_cs[p] && s_rd[p] && !s_wr[p]) begin
                            rv = (int'(s_addr[p]) < dep_of(d)) ? mem[d][s_addr[p]] : '0;
                            q[2*d+p].push_back('{rv, ecnt + lat_of(d) - 1});
                        end
                    end
                    for (int p = 1; p >= 0; p--) begin
                        if (s_cs[p] && s_wr[p] && int'(s_addr[p]) < dep_of(d)) begin
                            for (int i = 0; i < 4; i++)
                                if (s_be[p][i]) mem[d][s_addr[p]][8*i +: 8] = s_wd[p][8*i +: 8];
                        end
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        logic en_n;
        bit   due;
        int   d;
        if (init) begin
            en_n = clken & ~reset_req;
            for (int k = 0; k < 4; k++) begin
                d = k / 2;
                chk($sformatf("waitrequest[%0d]", k), DW'(o_wait[k]),
                    DW'((clr_left[d] > 0) || !en_n));
                due = en_n && (q[k].size() > 0) && (q[k][0].due == ecnt);
                if (due || o_valid[k])
                    chk($sformatf("readdatavalid[%0d]", k), DW'(o_valid[k]), DW'(due));
                if (due) begin
                    chk($sformatf("readdata[%0d]", k), o_data[k], q[k][0].data);
                    last_exp[k] = q[k][0].data;
                    void'(q[k].pop_front());
                end else if (!o_valid[k]) begin
                    chk($sformatf("readdata_hold[%0d]", k), o_data[k], last_exp[k]);
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic idle_all();
        for (int p = 0; p < 2; p++) begin
            s_cs[p] = 1'b0; s_rd[p] = 1'b0; s_wr[p] = 1'b0;
            s_addr[p] = '0; s_be[p] = '0; s_wd[p] = '0;
        end
    endtask

    task automatic op(input int p, input bit rd, input bit wr, input int addr,
                      input logic [3:0] be, input logic [DW-1:0] wd);
        s_cs[p] = 1'b1; s_rd[p] = rd; s_wr[p] = wr;
        s_addr[p] = AW'(addr); s_be[p] = be; s_wd[p] = wd;
    endtask

    initial begin
        idle_all();
        reset = 1'b1;
        tick(3);
        reset = 1'b0;
        tick(8);
        reset = 1'b1;                // restart the sweep part way through
        tick(1);
        reset = 1'b0;
        tick(20);

        for (int w = 0; w < 16; w++) begin
            op(0, 1, 0, w, 4'h0, '0);
            tick(1);
        end
        idle_all(); tick(3);

        op(0, 0, 1, 5, 4'hF, 32'hDEADBEEF); tick(1);
        op(0, 1, 0, 5, 4'h0, '0);            tick(1);
        idle_all(); tick(3);

        op(0, 0, 1, 3, 4'hF, 32'h11223344); tick(1);
        op(0, 0, 1, 3, 4'h5, 32'hAABBCCDD); tick(1);
        op(0, 1, 0, 3, 4'h0, '0);            tick(1);
        idle_all(); tick(3);

        op(0, 0, 1, 7, 4'h1, 32'h000000FF);
        op(1, 0, 1, 7, 4'hF, 32'h12345678); tick(1);
        idle_all();
        op(0, 1, 0, 7, 4'h0, '0);            tick(1);
        idle_all(); tick(3);

        op(0, 0, 1, 2, 4'hF, 32'h00000055); tick(1);
        op(0, 1, 0, 2, 4'h0, '0);            tick(1);
        idle_all(); clken = 1'b0; tick(3);
        clken = 1'b1; tick(4);
        op(1, 1, 0, 2, 4'h0, '0);            tick(1);
        idle_all(); reset_req = 1'b1; tick(3);
        reset_req = 1'b0; tick(4);

        op(0, 0, 1, 12, 4'hF, 32'hFFFFFFFF); tick(1);
        idle_all();
        for (int w = 0; w < 10; w++) begin
            op(1, 1, 0, w, 4'h0, '0);
            tick(1);
        end
        idle_all();
        op(0, 1, 0, 12, 4'h0, '0);           tick(1);
        op(0, 1, 1, 4, 4'hF, 32'hA5A5A5A5); tick(1);
        idle_all(); tick(4);

        repeat (600) begin
            for (int p = 0; p < 2; p++) begin
                s_cs[p]   = ($urandom_range(0, 3) != 0);
                s_rd[p]   = 1'($urandom_range(0, 1));
                s_wr[p]   = 1'($urandom_range(0, 1));
                s_addr[p] = AW'($urandom_range(0, 15));
                s_be[p]   = 4'($urandom);
                s_wd[p]   = $urandom;
            end
            clken     = ($urandom_range(0, 9) != 0);
            reset_req = ($urandom_range(0, 19) == 0);
            tick(1);
        end

        idle_all(); clken = 1'b1; reset_req = 1'b0;
        tick(6);
        for (int k = 0; k < 4; k++)
            chk($sformatf("beats_outstanding[%0d]", k), DW'(q[k].size()), '0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
